test_generator: RTL and testbench
=================================

# test_generator

Self-checking stimulus source for the 4-bit arithmetic unit and its carry-look-ahead variant. It sweeps every combination of operands A and B, carry-in and the two select lines, one vector per clock. Alongside each vector it drives the golden expected result, so a downstream result analyzer can compare it against the unit under test in the same cycle.

## Interface
- No parameters. Widths are fixed: 4-bit operands and an 11-bit vector index.
- `clk` (in, 1): single clock; all state updates on the rising edge.
- `rst` (in, 1): reset, synchronous and active-high.
- `en` (in, 1): advance to the next vector when 1; hold when 0.
- `a` (out, 4): operand A.
- `b` (out, 4): operand B.
- `select0` (out, 1): select line s0.
- `select1` (out, 1): select line s1.
- `carray_in` (out, 1): carry-in to the unit under test.
- `D` (out, 4): expected 4-bit result for the vector currently on the outputs.
- `D_cout` (out, 1): expected carry-out, bit 4 of the 5-bit sum.
- `done` (out, 1): high once the final vector has been presented and consumed.

## Operation
- An 11-bit index `idx` is the concatenation {a[3:0], b[3:0], carray_in, select0, select1}. `select1` is the LSB and `a[3]` is the MSB.
- All stimulus outputs are direct register fields of `idx`.
- The expected result is computed as a 5-bit sum {D_cout, D} = X + Y + Z, selected by {select1, select0, carray_in}:
  - 000: add. a + b.
  - 001: add with carry. a + b + 1.
  - 010: subtract with borrow. a + ~b, i.e. a − b − 1.
  - 011: subtract. a + ~b + 1, i.e. a − b.
  - 100: transfer A. a; D_cout = 0.
  - 101: increment. a + 1.
  - 110: decrement. a + 4'b1111.
  - 111: transfer A. a; D_cout = 0.
- ~b is the 4-bit complement. All arithmetic is 5-bit unsigned; D takes the low 4 bits with wrap-around, and D_cout takes bit 4.
- Sweep: from idx = 0 to idx = 2047 (a=15, b=15, carray_in=1, select0=1, select1=1), one step per enabled clock.
- Terminal: when en=1 while idx = 2047, set done=1 and hold idx at 2047. No wrap-around. While done=1, en is ignored.

## Timing
- Reset (synchronous, rst=1 at a rising edge): idx=0, so a=b=0 and all selects and carray_in are 0. D=0, D_cout=0, done=0. Reset has priority over en.
- Reset mid-sweep restarts at vector 0 on the next edge.
- D and D_cout are registered together with idx; they are computed from idx_next. Expected and stimulus therefore change on the same edge.
- Latency: zero cycles between a vector and its expected value. The result analyzer samples both on the following rising edge.
- en=0 holds every output stable.
- A full sweep takes 2048 enabled cycles from reset until done=1.

## Structure
- Shared package `alu_tb_pkg` holds:
  - operation codes as 3-bit localparams over {s1, s0, cin}: OP_ADD, OP_ADDC, OP_SUBB, OP_SUB, OP_TFR, OP_INC, OP_DEC, OP_TFR2;
  - `VEC_LAST = 11'd2047`.
- One sub-module, `alu_ref_model`, is purely combinational: it maps (a, b, cin, s0, s1) to {cout, d}.
- The top level holds the index register, the done flag and the output registers.

## Test plan
- Reset, then hold en=0 for 5 cycles: all outputs remain 0 and done=0.
- After reset, set en=1 for 1 cycle: select1=1, all other stimulus 0 (transfer), D=0, D_cout=0.
- Step to idx=666 (a=5, b=3, select0=1, carray_in=0): D=1, D_cout=1. At idx=670 (carray_in=1): D=2, D_cout=1.
- Add-with-carry with a=9, b=8, carray_in=1, selects 0: D=2, D_cout=1. Decrement with a=0: D=15, D_cout=0. Increment with a=15: D=0, D_cout=1.
- Run 2048 enabled cycles: last vector shows a=b=15 and D=15. On the next enabled edge done=1 and idx holds. Asserting rst then returns all outputs to 0 and clears done.
- Assert rst mid-sweep at idx=1000 with en=1: on the next edge idx=0, D=0, done=0.

Source files
------------

// File: rtl/alu_tb_pkg.sv
// Shared definitions for the 4-bit arithmetic unit stimulus generator.
//   - Operation codes over {s1, s0, cin}.
//   - Vector index layout and the final index of the sweep.
package alu_tb_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;  // a + b
    localparam logic [2:0] OP_ADDC = 3'b001;  // a + b + 1
    localparam logic [2:0] OP_SUBB = 3'b010;  // a + ~b
    localparam logic [2:0] OP_SUB  = 3'b011;  // a + ~b + 1
    localparam logic [2:0] OP_TFR  = 3'b100;  // a
    localparam logic [2:0] OP_INC  = 3'b101;  // a + 1
    localparam logic [2:0] OP_DEC  = 3'b110;  // a + 4'b1111
    localparam logic [2:0] OP_TFR2 = 3'b111;  // a

    localparam logic [10:0] VEC_LAST = 11'd2047;

    // Vector index layout: a is the MSB field, s1 the LSB.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       s0;
        logic       s1;
    } vec_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-bit arithmetic unit.
// Ports:
//   i_a, i_b    : 4-bit operands
//   i_cin       : carry-in
//   i_s0, i_s1  : select lines
//   o_d         : 4-bit result (low bits of the 5-bit sum)
//   o_cout      : carry-out (bit 4 of the 5-bit sum)
module alu_ref_model
    import alu_tb_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    input  logic       i_s0,
    input  logic       i_s1,
    output logic [3:0] o_d,
    output logic       o_cout
);

    logic [2:0] w_op;
    logic [4:0] w_x;
    logic [4:0] w_y;
    logic [4:0] w_z;
    logic [4:0] w_sum;

    assign w_op = {i_s1, i_s0, i_cin};
    assign w_x  = {1'b0, i_a};

    // Every operation is X + Y + Z; only Y and Z depend on the opcode.
    always_comb begin
        w_y = '0;
        w_z = '0;
        case (w_op)
            OP_ADD:  w_y = {1'b0, i_b};
            OP_ADDC: begin
                w_y = {1'b0, i_b};
                w_z = 5'd1;
            end
            OP_SUBB: w_y = {1'b0, ~i_b};
            OP_SUB:  begin
                w_y = {1'b0, ~i_b};
                w_z = 5'd1;
            end
            OP_TFR:  w_y = '0;
            OP_INC:  w_z = 5'd1;
            OP_DEC:  w_y = 5'b01111;
            OP_TFR2: w_y = '0;
            default: w_y = '0;
        endcase
    end

    assign w_sum          = w_x + w_y + w_z;
    assign {o_cout, o_d}  = w_sum;

endmodule

// File: rtl/test_generator.sv
// Exhaustive stimulus source for the 4-bit arithmetic unit.
// Sweeps all 2048 combinations of {a, b, carray_in, select0, select1},
// one vector per enabled clock, and drives the expected result alongside.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   en        : advance to next vector when high
//   a, b      : operands
//   select0/1 : select lines
//   carray_in : carry-in to the unit under test
//   D, D_cout : expected result and carry-out for the current vector
//   done      : final vector has been presented and consumed
module test_generator
    import alu_tb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       select0,
    output logic       select1,
    output logic       carray_in,
    output logic [3:0] D,
    output logic       D_cout,
    output logic       done
);

    logic [10:0] r_idx;
    logic        r_done;
    logic [3:0]  r_d;
    logic        r_cout;

    logic [10:0] w_idx_next;
    logic        w_done_next;
    vec_t        w_vec_next;
    vec_t        w_vec_cur;
    logic [3:0]  w_d_next;
    logic        w_cout_next;

    always_comb begin
        w_idx_next  = r_idx;
        w_done_next = r_done;
        if (en && !r_done) begin
            if (r_idx == VEC_LAST) begin
                w_done_next = 1'b1;
            end else begin
                w_idx_next = r_idx + 11'd1;
            end
        end
    end

    assign w_vec_next = vec_t'(w_idx_next);
    assign w_vec_cur  = vec_t'(r_idx);

    // Expected result is computed from the next index so that it is
    // registered on the same edge as the stimulus it belongs to.
    alu_ref_model u_ref (
        .i_a    (w_vec_next.a),
        .i_b    (w_vec_next.b),
        .i_cin  (w_vec_next.cin),
        .i_s0   (w_vec_next.s0),
        .i_s1   (w_vec_next.s1),
        .o_d    (w_d_next),
        .o_cout (w_cout_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_done <= 1'b0;
            r_d    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_idx  <= w_idx_next;
            r_done <= w_done_next;
            r_d    <= w_d_next;
            r_cout <= w_cout_next;
        end
    end

    assign a         = w_vec_cur.a;
    assign b         = w_vec_cur.b;
    assign carray_in = w_vec_cur.cin;
    assign select0   = w_vec_cur.s0;
    assign select1   = w_vec_cur.s1;
    assign D         = r_d;
    assign D_cout    = r_cout;
    assign done      = r_done;

endmodule

// File: tb/tb_test_generator.sv
module tb_test_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] a;
    logic [3:0] b;
    logic       select0;
    logic       select1;
    logic       carray_in;
    logic [3:0] D;
    logic       D_cout;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain vector number and completion flag.
    int m_idx  = 0;
    int m_done = 0;
    int n_en   = 0;

    test_generator dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .b         (b),
        .select0   (select0),
        .select1   (select1),
        .carray_in (carray_in),
        .D         (D),
        .D_cout    (D_cout),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected outputs for vector number idx, from the operation table.
    task automatic expect_vec(input int idx, output int ea, output int eb,
                              output int ecin, output int es0, output int es1,
                              output int ed, output int ecout);
        int r;
        ea   = idx / 128;
        eb   = (idx / 8) % 16;
        ecin = (idx / 4) % 2;
        es0  = (idx / 2) % 2;
        es1  = idx % 2;
        case (es1 * 4 + es0 * 2 + ecin)
            0:       r = ea + eb;
            1:       r = ea + eb + 1;
            2:       r = ea + (15 - eb);
            3:       r = ea + (15 - eb) + 1;
            5:       r = ea + 1;
            6:       r = ea + 15;
            default: r = ea;            // transfer
        endcase
        ed    = r % 16;
        ecout = (r / 16) % 2;
    endtask

    task automatic check_all(input string tag);
        int ea, eb, ecin, es0, es1, ed, ecout;
        expect_vec(m_idx, ea, eb, ecin, es0, es1, ed, ecout);
        check({tag, "_a"},    int'(a),         ea);
        check({tag, "_b"},    int'(b),         eb);
        check({tag, "_cin"},  int'(carray_in), ecin);
        check({tag, "_s0"},   int'(select0),   es0);
        check({tag, "_s1"},   int'(select1),   es1);
        check({tag, "_D"},    int'(D),         ed);
        check({tag, "_cout"}, int'(D_cout),    ecout);
        check({tag, "_done"}, int'(done),      m_done);
    endtask

    // One clock: drive inputs, advance the model, sample 1ns after the edge.
    task automatic tick(input bit r, input bit e, input string tag);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            m_idx  = 0;
            m_done = 0;
            n_en   = 0;
        end else if (e) begin
            n_en++;
            if (m_done == 0) begin
                if (m_idx == 2047) m_done = 1;
                else               m_idx++;
            end
        end
        #1;
        check_all(tag);
    endtask

    function automatic int dut_idx();
        return {a, b, carray_in, select0, select1};
    endfunction

    task automatic run_to(input int target);
        int guard = 0;
        while (m_idx != target && guard < 20000) begin
            tick(1'b0, ($urandom_range(0, 3) != 0), "sweep");
            guard++;
        end
        check("reach_idx", dut_idx(), target);
    endtask

    initial begin
        int guard;

        // Reset and idle
        tick(1'b1, 1'b0, "rst");
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, "idle");
        check("idle_D", int'(D), 0);

        // First enabled step: idx 1 = transfer with select1 high
        tick(1'b0, 1'b1, "first");
        check("first_s1", int'(select1), 1);
        check("first_D",  int'(D), 0);

        // Decrement with a=0 (idx 3)
        run_to(3);
        check("dec_D",    int'(D), 15);
        check("dec_cout", int'(D_cout), 0);

        // Subtract with borrow: a=5, b=3
        run_to(666);
        check("subb_D",    int'(D), 1);
        check("subb_cout", int'(D_cout), 1);
        run_to(670);
        check("sub_D",    int'(D), 2);
        check("sub_cout", int'(D_cout), 1);

        // Reset mid-sweep with en high
        run_to(1000);
        tick(1'b1, 1'b1, "midrst");
        check("midrst_idx",  dut_idx(), 0);
        check("midrst_D",    int'(D), 0);
        check("midrst_done", int'(done), 0);

        // Second sweep from reset, counting enabled cycles until done
        run_to(1220);
        check("addc_D",    int'(D), 2);
        check("addc_cout", int'(D_cout), 1);
        run_to(1925);
        check("inc_D",    int'(D), 0);
        check("inc_cout", int'(D_cout), 1);
        run_to(2047);
        check("last_a", int'(a), 15);
        check("last_b", int'(b), 15);
        check("last_D", int'(D), 15);
        check("last_done", int'(done), 0);

        guard = 0;
        while (done !== 1'b1 && guard < 50) begin
            tick(1'b0, ($urandom_range(0, 1) != 0), "tail");
            guard++;
        end
        check("done_seen", int'(done === 1'b1), 1);
        check("sweep_len", n_en, 2048);

        // Done holds; en ignored
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, "hold");
        check("hold_idx", dut_idx(), 2047);

        // Reset clears everything
        tick(1'b1, 1'b0, "endrst");
        check("endrst_done", int'(done), 0);
        check("endrst_D",    int'(D), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
